// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, opcodes, control FSM states and decode record.
// The datapath ALU imports alu_op_e from here so the encodings stay in one place.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SHR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_ROR = 4'd6,
        ALU_ROL = 4'd7,
        ALU_NEG = 4'd10,
        ALU_NOT = 4'd11
    } alu_op_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_T0    = 3'd1,
        ST_T1    = 3'd2,
        ST_T2    = 3'd3,
        ST_T3    = 3'd4,
        ST_T4    = 3'd5,
        ST_T5    = 3'd6,
        ST_HALT  = 3'd7
    } cu_state_e;

    // ALU3: rd <= rb op rc; UNARY: rd <= op rb; illegal opcodes fold into NOP.
    typedef enum logic [1:0] {
        CLS_NOP   = 2'd0,
        CLS_ALU3  = 2'd1,
        CLS_UNARY = 2'd2,
        CLS_HALT  = 2'd3
    } op_class_e;

    typedef struct packed {
        op_class_e   cls;
        alu_op_e     alu;
        logic [15:0] ra_sel;
        logic [15:0] rb_sel;
        logic [15:0] rc_sel;
    } dec_t;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control strobes between the control unit (master) and the datapath (slave).
// The datapath supplies the instruction register and memory-ready; everything else flows out.
interface control_unit_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic        pc_out;
    logic        pc_in;
    logic        mar_in;
    logic        mdr_in;
    logic        mdr_out;
    logic        read;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        z_low_out;
    logic        inc_pc;
    logic [15:0] gpr_in;
    logic [15:0] gpr_out;
    logic [3:0]  alu_op;
    logic        run;

    modport master (
        input  ir, mem_ready,
        output pc_out, pc_in, mar_in, mdr_in, mdr_out, read, ir_in,
               y_in, z_in, z_low_out, inc_pc, gpr_in, gpr_out, alu_op, run
    );

    modport slave (
        output ir, mem_ready,
        input  pc_out, pc_in, mar_in, mdr_in, mdr_out, read, ir_in,
               y_in, z_in, z_low_out, inc_pc, gpr_in, gpr_out, alu_op, run
    );
endinterface

// File: rtl/ir_decode.sv
// Combinational instruction decode: opcode class, mapped ALU op and one-hot register selects.
// Zero latency; no flow control.
module ir_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output dec_t        dec
);

    logic [4:0] opcode;
    logic       unused_ir_low;

    assign opcode        = ir[31:27];
    assign unused_ir_low = ^ir[14:0];

    always_comb begin
        dec.cls    = CLS_NOP;
        dec.alu    = ALU_AND;
        dec.ra_sel = onehot16(ir[26:23]);
        dec.rb_sel = onehot16(ir[22:19]);
        dec.rc_sel = onehot16(ir[18:15]);
        case (opcode)
            OP_ADD:  begin dec.cls = CLS_ALU3;  dec.alu = ALU_ADD; end
            OP_SUB:  begin dec.cls = CLS_ALU3;  dec.alu = ALU_SUB; end
            OP_AND:  begin dec.cls = CLS_ALU3;  dec.alu = ALU_AND; end
            OP_OR:   begin dec.cls = CLS_ALU3;  dec.alu = ALU_OR;  end
            OP_SHR:  begin dec.cls = CLS_ALU3;  dec.alu = ALU_SHR; end
            OP_SHL:  begin dec.cls = CLS_ALU3;  dec.alu = ALU_SHL; end
            OP_ROR:  begin dec.cls = CLS_ALU3;  dec.alu = ALU_ROR; end
            OP_ROL:  begin dec.cls = CLS_ALU3;  dec.alu = ALU_ROL; end
            OP_NEG:  begin dec.cls = CLS_UNARY; dec.alu = ALU_NEG; end
            OP_NOT:  begin dec.cls = CLS_UNARY; dec.alu = ALU_NOT; end
            OP_NOP:  dec.cls = CLS_NOP;
            OP_HALT: dec.cls = CLS_HALT;
            default: dec.cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control FSM: fetch (T0-T2, T1 stalls on mem_ready) then execute (T3-T5).
// Outputs are a Moore decode of state and ir, so an async reset zeroes them immediately.
module control_unit
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    control_unit_if.master bus,
    output cu_state_e      state
);

    dec_t dec;

    ir_decode u_ir_decode (
        .ir  (bus.ir),
        .dec (dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RESET;
        end else begin
            case (state)
                ST_RESET: state <= ST_T0;
                ST_T0:    state <= ST_T1;
                ST_T1:    state <= bus.mem_ready ? ST_T2 : ST_T1;
                ST_T2: begin
                    case (dec.cls)
                        CLS_NOP:  state <= ST_T0;
                        CLS_HALT: state <= ST_HALT;
                        default:  state <= ST_T3;
                    endcase
                end
                ST_T3:    state <= ST_T4;
                ST_T4:    state <= (dec.cls == CLS_UNARY) ? ST_T0 : ST_T5;
                ST_T5:    state <= ST_T0;
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_RESET;
            endcase
        end
    end

    // Exactly one bus driver per active state; RESET and HALT drive nothing.
    always_comb begin
        bus.pc_out    = 1'b0;
        bus.pc_in     = 1'b0;
        bus.mar_in    = 1'b0;
        bus.mdr_in    = 1'b0;
        bus.mdr_out   = 1'b0;
        bus.read      = 1'b0;
        bus.ir_in     = 1'b0;
        bus.y_in      = 1'b0;
        bus.z_in      = 1'b0;
        bus.z_low_out = 1'b0;
        bus.inc_pc    = 1'b0;
        bus.gpr_in    = 16'h0000;
        bus.gpr_out   = 16'h0000;
        bus.alu_op    = ALU_AND;
        bus.run       = (state != ST_RESET) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.z_in   = 1'b1;
                bus.alu_op = ALU_ADD;
            end
            ST_T1: begin
                bus.z_low_out = 1'b1;
                bus.pc_in     = 1'b1;
                bus.read      = 1'b1;
                bus.mdr_in    = 1'b1;
            end
            ST_T2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (dec.cls == CLS_ALU3) begin
                    bus.gpr_out = dec.rb_sel;
                    bus.y_in    = 1'b1;
                end else if (dec.cls == CLS_UNARY) begin
                    bus.gpr_out = dec.rb_sel;
                    bus.z_in    = 1'b1;
                    bus.alu_op  = dec.alu;
                end
            end
            ST_T4: begin
                if (dec.cls == CLS_ALU3) begin
                    bus.gpr_out = dec.rc_sel;
                    bus.z_in    = 1'b1;
                    bus.alu_op  = dec.alu;
                end else if (dec.cls == CLS_UNARY) begin
                    bus.z_low_out = 1'b1;
                    bus.gpr_in    = dec.ra_sel;
                end
            end
            ST_T5: begin
                bus.z_low_out = 1'b1;
                bus.gpr_in    = dec.ra_sel;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios plus random instructions against a
// per-cycle expected-step list built from the instruction-set rules.
module tb_control_unit;
    import cpu_pkg::*;

    logic      clk = 1'b0;
    logic      reset_n = 1'b0;
    cu_state_e state;

    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .state   (state)
    );

    localparam logic [11:0] M_RUN  = 12'h800;
    localparam logic [11:0] M_PCO  = 12'h400;
    localparam logic [11:0] M_PCI  = 12'h200;
    localparam logic [11:0] M_MARI = 12'h100;
    localparam logic [11:0] M_MDRI = 12'h080;
    localparam logic [11:0] M_MDRO = 12'h040;
    localparam logic [11:0] M_RD   = 12'h020;
    localparam logic [11:0] M_IRI  = 12'h010;
    localparam logic [11:0] M_YI   = 12'h008;
    localparam logic [11:0] M_ZI   = 12'h004;
    localparam logic [11:0] M_ZLO  = 12'h002;
    localparam logic [11:0] M_INC  = 12'h001;

    typedef struct {
        cu_state_e   st;
        logic [11:0] sb;
        logic [15:0] gi;
        logic [15:0] go;
        logic [3:0]  alu;
        logic        mr;
    } step_t;

    step_t q[$];
    int    n_chk = 0;
    int    n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [11:0] strobes();
        return {bus.run, bus.pc_out, bus.pc_in, bus.mar_in, bus.mdr_in, bus.mdr_out,
                bus.read, bus.ir_in, bus.y_in, bus.z_in, bus.z_low_out, bus.inc_pc};
    endfunction

    function automatic step_t mk(cu_state_e st, logic [11:0] sb, logic [15:0] gi,
                                 logic [15:0] go, logic [3:0] alu, logic mr);
        step_t s;
        s.st = st; s.sb = sb; s.gi = gi; s.go = go; s.alu = alu; s.mr = mr;
        return s;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction with a given T1 stall.
    task automatic build(input logic [31:0] ir, input int stall);
        int          op;
        int          alu3_tab[8] = '{2, 3, 0, 1, 4, 5, 6, 7};
        logic [15:0] oh_a, oh_b, oh_c;
        op   = int'(ir[31:27]);
        oh_a = 16'(1) << ir[26:23];
        oh_b = 16'(1) << ir[22:19];
        oh_c = 16'(1) << ir[18:15];
        q.delete();
        q.push_back(mk(ST_T0, M_RUN | M_PCO | M_MARI | M_INC | M_ZI, 16'h0, 16'h0, 4'd2, 1'b1));
        for (int i = 0; i < stall; i++)
            q.push_back(mk(ST_T1, M_RUN | M_ZLO | M_PCI | M_RD | M_MDRI, 16'h0, 16'h0, 4'd0, 1'b0));
        q.push_back(mk(ST_T1, M_RUN | M_ZLO | M_PCI | M_RD | M_MDRI, 16'h0, 16'h0, 4'd0, 1'b1));
        q.push_back(mk(ST_T2, M_RUN | M_MDRO | M_IRI, 16'h0, 16'h0, 4'd0, 1'b1));
        if (op >= 3 && op <= 10) begin
            q.push_back(mk(ST_T3, M_RUN | M_YI, 16'h0, oh_b, 4'd0, 1'b1));
            q.push_back(mk(ST_T4, M_RUN | M_ZI, 16'h0, oh_c, 4'(alu3_tab[op-3]), 1'b1));
            q.push_back(mk(ST_T5, M_RUN | M_ZLO, oh_a, 16'h0, 4'd0, 1'b1));
        end else if (op == 16 || op == 17) begin
            q.push_back(mk(ST_T3, M_RUN | M_ZI, 16'h0, oh_b, (op == 16) ? 4'd10 : 4'd11, 1'b1));
            q.push_back(mk(ST_T4, M_RUN | M_ZLO, oh_a, 16'h0, 4'd0, 1'b1));
        end else if (op == 27) begin
            for (int i = 0; i < 10; i++)
                q.push_back(mk(ST_HALT, 12'h000, 16'h0, 16'h0, 4'd0, 1'b1));
        end
    endtask

    task automatic compare(input step_t s, input string tag);
        check({tag, ".state"}, 32'(state), 32'(s.st));
        check({tag, ".strobes"}, 32'(strobes()), 32'(s.sb));
        check({tag, ".gpr_in"}, 32'(bus.gpr_in), 32'(s.gi));
        check({tag, ".gpr_out"}, 32'(bus.gpr_out), 32'(s.go));
        check({tag, ".alu_op"}, 32'(bus.alu_op), 32'(s.alu));
    endtask

    task automatic check_reset_state(input string tag);
        compare(mk(ST_RESET, 12'h000, 16'h0, 16'h0, 4'd0, 1'b1), tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        #1 check_reset_state(tag);
        @(negedge clk);
        check_reset_state(tag);
        reset_n = 1'b1;
    endtask

    // cut > 0 stops after that many steps (used to interrupt an instruction).
    task automatic run_instr(input string tag, input logic [31:0] ir, input int stall, input int cut);
        int n;
        build(ir, stall);
        n = (cut > 0) ? cut : q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) bus.ir = ir;
            bus.mem_ready = q[k].mr;
            compare(q[k], tag);
        end
        if (cut == 0 && ir[31:27] == 5'b11011) do_reset({tag, ".halt_rst"});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [4:0]  op;
        bus.ir        = 32'h0;
        bus.mem_ready = 1'b1;
        reset_n       = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("por");
        reset_n = 1'b1;

        run_instr("not_r5_r2", 32'h8A900000, 0, 0);
        run_instr("add_r2_r3_r0", 32'h19180000, 0, 0);
        run_instr("stall3", 32'h19180000, 3, 0);
        run_instr("halt", 32'hD8000000, 0, 0);
        run_instr("illegal", 32'hF8000000, 1, 0);
        run_instr("nop", 32'hD0000000, 0, 0);
        run_instr("add_r0_r0_r0", 32'h18000000, 0, 0);
        run_instr("neg_r0_r15", 32'h80780000, 2, 0);

        run_instr("add_abort", 32'h19180000, 0, 5);
        #2 reset_n = 1'b0;
        #1 check_reset_state("async_rst");
        @(negedge clk);
        check_reset_state("async_rst_hold");
        reset_n = 1'b1;
        run_instr("after_abort", 32'h29180000, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r  = $urandom();
            op = 5'($urandom_range(0, 31));
            run_instr("rand", {op, r[26:0]}, $urandom_range(0, 3), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The port clk SHALL be an input of width 1 and the single system clock; all state changes occur on its rising edge.
REQ-002 The port reset_n SHALL be an input of width 1; it is the asynchronous, active-low reset.
REQ-003 The port ir SHALL be an input of width 32 carrying the datapath instruction-register contents.
REQ-004 The port mem_ready SHALL be an input of width 1; memory read data is valid on m_data_in when it is high.
REQ-005 The ports pc_out, pc_in, mar_in, mdr_in, mdr_out, read, ir_in, y_in, z_in, z_low_out and inc_pc SHALL each be 1-bit outputs, active high, with datapath strobe meaning.
REQ-006 The ports gpr_in and gpr_out SHALL each be 16-bit outputs; they are one-hot register-file load and drive selects, with bit n selecting Rn.
REQ-007 The port alu_op SHALL be a 4-bit output with codes And=0, Or=1, Add=2, Sub=3, Shr=4, Shl=5, Ror=6, Rol=7, Neg=10, Not=11.
REQ-008 The port run SHALL be a 1-bit output that is high unless the unit is in HALT or RESET.

Function
REQ-009 Instruction fields SHALL be opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19] and rc=ir[18:15].
REQ-010 Supported opcodes SHALL be add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, neg 10000, not 10001, nop 11010 and halt 11011; all other opcodes SHALL execute as nop.
REQ-011 The FSM states SHALL be RESET, T0, T1, T2, T3, T4, T5 and HALT; outputs SHALL be a Moore decode of the state and ir only.
REQ-012 In T0, pc_out, mar_in, inc_pc and z_in SHALL be asserted with alu_op=Add; the next state is always T1.
REQ-013 In T1, z_low_out, pc_in, read and mdr_in SHALL be asserted; the FSM stays in T1 while mem_ready=0 and goes to T2 on the first edge with mem_ready=1.
REQ-014 In T2, mdr_out and ir_in SHALL be asserted; the next state is T3, except nop/illegal go to T0 and halt goes to HALT.
REQ-015 For three-register ALU ops, T3 SHALL assert gpr_out[rb] and y_in; T4 SHALL assert gpr_out[rc], z_in and the mapped alu_op; T5 SHALL assert z_low_out and gpr_in[ra]; the state after T5 is T0.
REQ-016 For neg/not, T3 SHALL assert gpr_out[rb], z_in and alu_op Neg/Not; T4 SHALL assert z_low_out and gpr_in[ra]; the state after T4 is T0.
REQ-017 Exactly one bus driver (pc_out, mdr_out, z_low_out or a single gpr_out bit) SHALL be active in any state; in states with no driver, none are active.
REQ-018 alu_op SHALL be 0 in every state other than T0, T3 (neg/not) and T4 (three-register ops).
REQ-019 HALT SHALL assert no strobes and hold until reset.
REQ-020 ra=rb=rc SHALL be legal; R0 SHALL be writable like any other register.

Reset
REQ-021 While reset_n=0, the state SHALL be RESET and every output 0, including mid-instruction and mid-T1 stall.
REQ-022 The first rising edge with reset_n=1 SHALL move RESET to T0.

Structure
REQ-023 cpu_pkg SHALL hold the alu_op codes, the opcode constants and the state encoding; the existing datapath SHALL share the alu_op codes from it.
REQ-024 A combinational sub-module ir_decode SHALL produce the opcode class and the one-hot ra/rb/rc selects (4-to-16); control_unit holds the FSM.

Verification
REQ-025 A bench SHALL apply reset then ir=0x8A900000 (not R5,R2) with mem_ready tied high, and SHALL observe T0..T4 in 5 cycles, gpr_out=0x0004 with alu_op=11 in T3, gpr_in=0x0020 in T4, and then T0.
REQ-026 A bench SHALL apply ir=0x19180000 (add R2,R3,R0) and SHALL observe y_in with gpr_out=0x0008 in T3, alu_op=2 with gpr_out=0x0001 in T4, and gpr_in=0x0004 in T5.
REQ-027 A bench SHALL hold mem_ready=0 for 3 cycles in T1 and SHALL observe T1 held for 4 cycles with read and mdr_in high throughout, followed by T2.
REQ-028 A bench SHALL apply ir=0xD8000000 (halt) and SHALL observe HALT after T2 with run=0 and all strobes 0 for 10 cycles, and T0 after a reset pulse.
REQ-029 A bench SHALL assert reset_n=0 asynchronously in T4 of an add and SHALL observe all outputs 0 immediately, RESET state, and restart at T0.
REQ-030 A bench SHALL apply ir=0xF8000000 (illegal opcode) and SHALL observe T2 followed by T0 with no gpr_in bit ever set.
